// File: rtl/ula_arbiter_pkg.sv
// Shared types and defaults for the two-requester ULA arbiter.
// Optional grant statistics are enabled with ULA_ARB_STATS_EN.
package ula_arb_pkg;

    localparam int W_DEF     = 4;
    localparam int SEL_W_DEF = 3;
    localparam int CNT_W     = 4;
    localparam int GCNT_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef logic req_idx_t;

    function automatic logic [GCNT_W-1:0] sat_inc(
        input logic [GCNT_W-1:0] v
    );
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ula_arbiter_if.sv
// Requester channels, ULA drive/return and status for ula_arbiter.
// Grant counters are present only with ULA_ARB_STATS_EN defined.
interface ula_arbiter_if
    import ula_arb_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int SEL_W = SEL_W_DEF
);

    logic             r0_req_valid;
    logic             r0_req_ready;
    logic [W-1:0]     r0_op_a;
    logic [W-1:0]     r0_op_b;
    logic [SEL_W-1:0] r0_sel;
    logic             r0_rsp_valid;
    logic             r0_rsp_ready;
    logic [W-1:0]     r0_rsp_data;

    logic             r1_req_valid;
    logic             r1_req_ready;
    logic [W-1:0]     r1_op_a;
    logic [W-1:0]     r1_op_b;
    logic [SEL_W-1:0] r1_sel;
    logic             r1_rsp_valid;
    logic             r1_rsp_ready;
    logic [W-1:0]     r1_rsp_data;

    logic [W-1:0]     ula_op_a;
    logic [W-1:0]     ula_op_b;
    logic [SEL_W-1:0] ula_sel;
    logic [W-1:0]     ula_out;

    logic             busy;

`ifdef ULA_ARB_STATS_EN
    logic [GCNT_W-1:0] r0_grant_cnt;
    logic [GCNT_W-1:0] r1_grant_cnt;
`endif

    // Requester side plus the external ULA result
    modport master (
        output r0_req_valid, r0_op_a, r0_op_b, r0_sel, r0_rsp_ready,
        output r1_req_valid, r1_op_a, r1_op_b, r1_sel, r1_rsp_ready,
        output ula_out,
        input  r0_req_ready, r0_rsp_valid, r0_rsp_data,
        input  r1_req_ready, r1_rsp_valid, r1_rsp_data,
        input  ula_op_a, ula_op_b, ula_sel,
        input  busy
`ifdef ULA_ARB_STATS_EN
        , input r0_grant_cnt, r1_grant_cnt
`endif
    );

    modport slave (
        input  r0_req_valid, r0_op_a, r0_op_b, r0_sel, r0_rsp_ready,
        input  r1_req_valid, r1_op_a, r1_op_b, r1_sel, r1_rsp_ready,
        input  ula_out,
        output r0_req_ready, r0_rsp_valid, r0_rsp_data,
        output r1_req_ready, r1_rsp_valid, r1_rsp_data,
        output ula_op_a, ula_op_b, ula_sel,
        output busy
`ifdef ULA_ARB_STATS_EN
        , output r0_grant_cnt, r1_grant_cnt
`endif
    );

endinterface

// File: rtl/ula_arbiter_rr_arb2.sv
// Two-way round-robin picker; the previous winner is held by the caller.
// Grant is one-hot, or zero when nobody requests.
module rr_arb2
    import ula_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  req_idx_t   last_grant_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        unique case (1'b1)
            (req_i == 2'b11): gnt_o = last_grant_i ? 2'b01 : 2'b10;
            (req_i == 2'b01): gnt_o = 2'b01;
            (req_i == 2'b10): gnt_o = 2'b10;
            default:          gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/ula_arbiter.sv
// Shares one external ULA between two valid/ready requesters, round-robin.
// Define ULA_ARB_STATS_EN to add saturating per-requester grant counters.
module ula_arbiter
    import ula_arb_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int SEL_W   = SEL_W_DEF,
    parameter int ULA_LAT = 1
) (
    input logic          clk,
    input logic          rst,
    ula_arbiter_if.slave bus
);

    state_e           state_q, state_d;
    req_idx_t         last_q, last_d;
    req_idx_t         own_q, own_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     opa_q, opa_d;
    logic [W-1:0]     opb_q, opb_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [1:0]       vld_q, vld_d;
    logic [W-1:0]     d0_q, d0_d;
    logic [W-1:0]     d1_q, d1_d;

    logic [1:0] req;
    logic [1:0] gnt;
    logic [1:0] rdy;
    logic       acc;
    logic       rsp_hs;

    assign req = {bus.r1_req_valid, bus.r0_req_valid};

    rr_arb2 u_rr (
        .req_i        (req),
        .last_grant_i (last_q),
        .gnt_o        (gnt)
    );

    assign rdy    = (state_q == IDLE) ? gnt : 2'b00;
    assign acc    = |rdy;
    assign rsp_hs = (state_q == RESP) &&
                    (own_q ? bus.r1_rsp_ready : bus.r0_rsp_ready);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        own_d   = own_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sel_d   = sel_q;
        vld_d   = vld_q;
        d0_d    = d0_q;
        d1_d    = d1_q;
        unique case (state_q)
            IDLE: begin
                if (acc) begin
                    own_d   = gnt[1];
                    last_d  = gnt[1];
                    opa_d   = gnt[1] ? bus.r1_op_a : bus.r0_op_a;
                    opb_d   = gnt[1] ? bus.r1_op_b : bus.r0_op_b;
                    sel_d   = gnt[1] ? bus.r1_sel  : bus.r0_sel;
                    cnt_d   = CNT_W'(ULA_LAT - 1);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    if (own_q) d1_d = bus.ula_out;
                    else       d0_d = bus.ula_out;
                    vld_d[own_q] = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_hs) begin
                    vld_d   = 2'b00;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // last_q resets to 1 so requester 0 wins the first contested round
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            own_q   <= 1'b0;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            sel_q   <= '0;
            vld_q   <= 2'b00;
            d0_q    <= '0;
            d1_q    <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            own_q   <= own_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sel_q   <= sel_d;
            vld_q   <= vld_d;
            d0_q    <= d0_d;
            d1_q    <= d1_d;
        end
    end

    assign bus.r0_req_ready = rdy[0];
    assign bus.r1_req_ready = rdy[1];
    assign bus.r0_rsp_valid = vld_q[0];
    assign bus.r1_rsp_valid = vld_q[1];
    assign bus.r0_rsp_data  = d0_q;
    assign bus.r1_rsp_data  = d1_q;
    assign bus.ula_op_a     = opa_q;
    assign bus.ula_op_b     = opb_q;
    assign bus.ula_sel      = sel_q;
    assign bus.busy         = (state_q != IDLE);

`ifdef ULA_ARB_STATS_EN
    logic [GCNT_W-1:0] gc0_q, gc1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gc0_q <= '0;
            gc1_q <= '0;
        end else begin
            if (rdy[0]) gc0_q <= sat_inc(gc0_q);
            if (rdy[1]) gc1_q <= sat_inc(gc1_q);
        end
    end

    assign bus.r0_grant_cnt = gc0_q;
    assign bus.r1_grant_cnt = gc1_q;
`endif

endmodule

// File: tb/tb_ula_arbiter.sv
// Bench for ula_arbiter: two DUTs (ULA_LAT 1 and 3) against a transaction model.
// Define ULA_ARB_STATS_EN to also exercise the grant counters.
module tb_ula_arbiter;
    import ula_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       rv [2][2];
    logic [3:0] ra [2][2];
    logic [3:0] rb [2][2];
    logic [2:0] rs [2][2];
    logic       rr [2][2];

    int errs   = 0;
    int checks = 0;

    function automatic logic [3:0] ula_f(
        input logic [3:0] a, input logic [3:0] b, input logic [2:0] s
    );
        case (s)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ~a;
            3'd6: return a << 1;
            default: return ~(a & b);
        endcase
    endfunction

    function automatic int pick(input logic v0, input logic v1, input logic last);
        if (v0 && v1) return last ? 0 : 1;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic chk(input string nm, input int inst,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s inst%0d: got %0h want %0h @%0t",
                     nm, inst, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int LAT = (g == 0) ? 1 : 3;

        ula_arbiter_if #(.W(4), .SEL_W(3)) bus ();

        assign bus.r0_req_valid = rv[g][0];
        assign bus.r0_op_a      = ra[g][0];
        assign bus.r0_op_b      = rb[g][0];
        assign bus.r0_sel       = rs[g][0];
        assign bus.r0_rsp_ready = rr[g][0];
        assign bus.r1_req_valid = rv[g][1];
        assign bus.r1_op_a      = ra[g][1];
        assign bus.r1_op_b      = rb[g][1];
        assign bus.r1_sel       = rs[g][1];
        assign bus.r1_rsp_ready = rr[g][1];
        assign bus.ula_out = ula_f(bus.ula_op_a, bus.ula_op_b, bus.ula_sel);

        ula_arbiter #(.W(4), .SEL_W(3), .ULA_LAT(LAT)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        // Transaction model: owner, accept edge index, held operands, results
        int         own  = -1;
        int         cyc  = 0;
        int         acc  = 0;
        logic       last = 1'b1;
        logic [3:0] ma = '0, mb = '0;
        logic [2:0] ms = '0;
        logic [3:0] md [2] = '{4'h0, 4'h0};
        int         gc [2] = '{0, 0};

        initial forever begin
            int w;
            @(posedge clk or posedge rst);
            if (rst) begin
                own = -1; cyc = 0; acc = 0; last = 1'b1;
                ma = '0; mb = '0; ms = '0;
                md[0] = '0; md[1] = '0; gc[0] = 0; gc[1] = 0;
            end else begin
                if (own < 0) begin
                    w = pick(rv[g][0], rv[g][1], last);
                    if (w >= 0) begin
                        own = w; last = (w == 1);
                        ma = ra[g][w]; mb = rb[g][w]; ms = rs[g][w];
                        acc = cyc + 1;
                        if (gc[w] < 255) gc[w]++;
                    end
                end else if (cyc - acc >= LAT && rr[g][own]) begin
                    own = -1;
                end
                cyc++;
                if (own >= 0 && cyc - acc == LAT)
                    md[own] = ula_f(ma, mb, ms);
            end
        end

        initial forever begin
            int   w;
            logic ev;
            logic [23:0] act, exp;
            @(negedge clk);
            w  = pick(rv[g][0], rv[g][1], last);
            ev = (own >= 0) && (cyc - acc >= LAT);
            act = {bus.r1_req_ready, bus.r0_req_ready,
                   bus.r1_rsp_valid, bus.r0_rsp_valid, bus.busy,
                   bus.r1_rsp_data, bus.r0_rsp_data,
                   bus.ula_op_a, bus.ula_op_b, bus.ula_sel};
            exp = {(own < 0) && (w == 1), (own < 0) && (w == 0),
                   ev && (own == 1), ev && (own == 0), own >= 0,
                   md[1], md[0], ma, mb, ms};
            chk("outs", g, 32'(act), 32'(exp));
`ifdef ULA_ARB_STATS_EN
            chk("gcnt0", g, 32'(bus.r0_grant_cnt), 32'(gc[0]));
            chk("gcnt1", g, 32'(bus.r1_grant_cnt), 32'(gc[1]));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                rv[i][j] = 1'b0; rr[i][j] = 1'b0;
            end
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic setreq(input int i, input int j, input logic [3:0] a,
                          input logic [3:0] b, input logic [2:0] s);
        rv[i][j] = 1'b1; ra[i][j] = a; rb[i][j] = b; rs[i][j] = s;
    endtask

    int gq[$];

    initial begin
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                rv[i][j] = 1'b0; rr[i][j] = 1'b0;
                ra[i][j] = '0; rb[i][j] = '0; rs[i][j] = '0;
            end

        // Reset state, no requests
        do_reset();
        #1;
        chk("t1_busy", 0, 32'(gi[0].bus.busy), 0);
        chk("t1_rdy", 0, 32'({gi[0].bus.r1_req_ready, gi[0].bus.r0_req_ready}), 0);
        chk("t1_ula", 1, 32'({gi[1].bus.ula_op_a, gi[1].bus.ula_op_b}), 0);

        // Single r0 request, LAT 1
        setreq(0, 0, 4'b1100, 4'b0011, 3'b000);
        #1 chk("t2_rdy", 0, 32'(gi[0].bus.r0_req_ready), 1);
        tick();
        rv[0][0] = 1'b0;
        chk("t2_ula", 0, 32'({gi[0].bus.ula_op_a, gi[0].bus.ula_op_b,
                              gi[0].bus.ula_sel}), 32'({4'b1100, 4'b0011, 3'b000}));
        chk("t2_v_early", 0, 32'(gi[0].bus.r0_rsp_valid), 0);
        tick();
        chk("t2_v", 0, 32'(gi[0].bus.r0_rsp_valid), 1);
        chk("t2_d", 0, 32'(gi[0].bus.r0_rsp_data), 32'(4'b1111));
        chk("t2_v1", 0, 32'(gi[0].bus.r1_rsp_valid), 0);
        rr[0][0] = 1'b1;
        tick();
        rr[0][0] = 1'b0;
        chk("t2_done", 0, 32'({gi[0].bus.r0_rsp_valid, gi[0].bus.busy}), 0);

        // Both requesting continuously: alternation from r0
        do_reset();
        setreq(0, 0, 4'b1011, 4'b1111, 3'b001);
        setreq(0, 1, 4'b0000, 4'b1111, 3'b010);
        rr[0][0] = 1'b1; rr[0][1] = 1'b1;
        gq.delete();
        for (int k = 0; k < 12; k++) begin
            #1;
            if (gi[0].bus.r0_req_ready) gq.push_back(0);
            if (gi[0].bus.r1_req_ready) gq.push_back(1);
            tick();
        end
        rv[0][0] = 1'b0; rv[0][1] = 1'b0;
        chk("t3_ngnt", 0, 32'(gq.size()), 4);
        for (int k = 0; k < 4 && k < gq.size(); k++)
            chk("t3_order", 0, 32'(gq[k]), 32'(k % 2));
        chk("t3_d0", 0, 32'(gi[0].bus.r0_rsp_data), 32'(4'b1100));
        tick(); tick(); tick();
        rr[0][0] = 1'b0; rr[0][1] = 1'b0;

        // r1 response stalled while r0 waits
        do_reset();
        setreq(0, 1, 4'b1011, 4'b1111, 3'b010);
        tick();
        rv[0][1] = 1'b0;
        setreq(0, 0, 4'b0101, 4'b0011, 3'b011);
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("t4_v1", 0, 32'(gi[0].bus.r1_rsp_valid), 1);
            chk("t4_d1", 0, 32'(gi[0].bus.r1_rsp_data), 32'(4'b1011));
            chk("t4_rdy0", 0, 32'(gi[0].bus.r0_req_ready), 0);
            tick();
        end
        rr[0][1] = 1'b1;
        tick();
        rr[0][1] = 1'b0;
        #1 chk("t4_rdy0_after", 0, 32'(gi[0].bus.r0_req_ready), 1);
        chk("t4_v1_clr", 0, 32'(gi[0].bus.r1_rsp_valid), 0);
        tick();
        rv[0][0] = 1'b0;
        tick();
        chk("t4_d0", 0, 32'({gi[0].bus.r0_rsp_valid, gi[0].bus.r0_rsp_data}),
            32'({1'b1, 4'b0111}));
        rr[0][0] = 1'b1;
        tick();
        rr[0][0] = 1'b0;

        // Reset during EXEC, LAT 3
        do_reset();
        setreq(1, 0, 4'b0110, 4'b0001, 3'b000);
        tick();
        rv[1][0] = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("t5_busy", 1, 32'(gi[1].bus.busy), 0);
        chk("t5_ula", 1, 32'({gi[1].bus.ula_op_a, gi[1].bus.ula_op_b}), 0);
        #1 rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t5_novld", 1, 32'(gi[1].bus.r0_rsp_valid), 0);
        end
        setreq(1, 0, 4'b0110, 4'b0001, 3'b000);
        tick();
        rv[1][0] = 1'b0;
        tick(); tick(); tick();
        chk("t5_d0", 1, 32'({gi[1].bus.r0_rsp_valid, gi[1].bus.r0_rsp_data}),
            32'({1'b1, 4'b0111}));
        rr[1][0] = 1'b1;
        tick();
        rr[1][0] = 1'b0;

        // r1 alone, LAT 3: valid exactly three edges after the handshake
        do_reset();
        setreq(1, 1, 4'b1010, 4'b0110, 3'b111);
        tick();
        rv[1][1] = 1'b0;
        tick();
        chk("t6_v_t1", 1, 32'(gi[1].bus.r1_rsp_valid), 0);
        tick();
        chk("t6_v_t2", 1, 32'(gi[1].bus.r1_rsp_valid), 0);
        tick();
        chk("t6_v_t3", 1, 32'({gi[1].bus.r1_rsp_valid, gi[1].bus.r1_rsp_data}),
            32'({1'b1, 4'b1101}));
`ifdef ULA_ARB_STATS_EN
        chk("t6_gc1", 1, 32'(gi[1].bus.r1_grant_cnt), 1);
        rr[1][1] = 1'b1;
        rv[1][1] = 1'b1;
        repeat (300 * 5 + 20) tick();
        rv[1][1] = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        chk("t6_gc_sat", 1, 32'(gi[1].bus.r1_grant_cnt), 255);
        rr[1][1] = 1'b0;
`else
        rr[1][1] = 1'b1;
        tick();
        rr[1][1] = 1'b0;
`endif
        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
